sink_arbiter: RTL and testbench

Round-robin arbiter that shares one `sink` flit input (`data`/`req`/`busy`) between `N_PORTS` requesters, e.g. several router ejection channels feeding a single sink. Each requester holds a flit and `req` until it receives a one-cycle `ack`. The arbiter presents at most one flit per cycle to the sink and never issues while the sink reports `busy`. Optional per-port grant counters mirror the sink's windowed throughput measurement.

---
 rtl/sink_arbiter_pkg.sv | 18 +
 rtl/sink_arbiter_rr_pick.sv | 31 +++
 rtl/sink_arbiter.sv | 104 ++++++++++
 tb/tb_sink_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sink_arbiter_pkg.sv
// Shared definitions for sink_arbiter: default flit width, stats window width and index-width helper.
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

package sink_arbiter_pkg;

    localparam int DEFAULT_WINDOW_W = 26;

    // Bits needed to index n items; equals $clog2(n) for n >= 2.
    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sink_arbiter_rr_pick.sv
// Round-robin pick: lowest eligible index at or after ptr_i, searched over a doubled request vector.
module rr_pick #(
    parameter int N_PORTS = 4,
    parameter int PW      = 2
) (
    input  logic [N_PORTS-1:0] elig_i,
    input  logic [PW-1:0]      ptr_i,
    output logic               any_o,
    output logic [PW-1:0]      winner_o
);

    localparam int JW = PW + 1;

    logic [2*N_PORTS-1:0] dbl;
    logic [JW-1:0]        first;

    always_comb begin
        dbl = {elig_i, elig_i};
        // Bits below ptr in the lower copy are searched via the upper copy instead.
        for (int i = 0; i < 2*N_PORTS; i++) begin
            if (i < int'(ptr_i)) dbl[i] = 1'b0;
        end
        first = '0;
        for (int i = 2*N_PORTS-1; i >= 0; i--) begin
            if (dbl[i]) first = JW'(i);
        end
        winner_o = (first >= JW'(N_PORTS)) ? PW'(first - JW'(N_PORTS)) : PW'(first);
        any_o    = |elig_i;
    end

endmodule

// File: rtl/sink_arbiter.sv
// Round-robin arbiter sharing one sink flit input among N_PORTS requesters.
// Optional per-port windowed grant counters are built when SINK_ARB_STATS_EN is defined.
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

module sink_arbiter
    import sink_arbiter_pkg::*;
#(
    parameter int N_PORTS  = 4,
    parameter int DATA_W   = `ADDR_SZ,
    parameter int WINDOW_W = DEFAULT_WINDOW_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [N_PORTS-1:0]           req,
    input  logic [N_PORTS*DATA_W-1:0]    data_in,
    output logic [N_PORTS-1:0]           ack,
    output logic                         sink_req,
    output logic [DATA_W-1:0]            sink_data,
    input  logic                         sink_busy,
    output logic [N_PORTS*WINDOW_W-1:0]  grant_count
);

    localparam int PW = idx_w(N_PORTS);

    logic [PW-1:0]      ptr_q, ptr_d, winner;
    logic               any, issue;
    logic [N_PORTS-1:0] elig, ack_q, ack_d;
    logic               sink_req_q;
    logic [DATA_W-1:0]  sink_data_q, sink_data_d;

    rr_pick #(.N_PORTS(N_PORTS), .PW(PW)) u_pick (
        .elig_i   (elig),
        .ptr_i    (ptr_q),
        .any_o    (any),
        .winner_o (winner)
    );

    always_comb begin
        // A port acked this cycle is still holding the same flit, so mask it.
        elig        = req & ~ack_q;
        issue       = en & ~sink_busy & any;
        ack_d       = '0;
        ptr_d       = ptr_q;
        sink_data_d = sink_data_q;
        if (issue) begin
            ack_d[winner] = 1'b1;
            ptr_d         = (winner == PW'(N_PORTS-1)) ? '0 : winner + 1'b1;
            for (int i = 0; i < N_PORTS; i++) begin
                if (winner == PW'(i)) sink_data_d = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q       <= '0;
            sink_req_q  <= 1'b0;
            sink_data_q <= '0;
            ptr_q       <= '0;
        end else begin
            ack_q       <= ack_d;
            sink_req_q  <= issue;
            sink_data_q <= sink_data_d;
            ptr_q       <= ptr_d;
        end
    end

    assign ack       = ack_q;
    assign sink_req  = sink_req_q;
    assign sink_data = sink_data_q;

`ifdef SINK_ARB_STATS_EN
    logic [WINDOW_W-1:0]               sampler_q;
    logic [N_PORTS-1:0][WINDOW_W-1:0]  running_q, count_q;

    // The ack seen in the window's last cycle is folded into that window's result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sampler_q <= '0;
            running_q <= '0;
            count_q   <= '0;
        end else if (&sampler_q) begin
            sampler_q <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                count_q[i]   <= running_q[i] + WINDOW_W'(ack_q[i]);
                running_q[i] <= '0;
            end
        end else begin
            sampler_q <= sampler_q + 1'b1;
            for (int i = 0; i < N_PORTS; i++) begin
                running_q[i] <= running_q[i] + WINDOW_W'(ack_q[i]);
            end
        end
    end

    assign grant_count = count_q;
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_sink_arbiter.sv
// Directed and randomized bench for sink_arbiter (N_PORTS=4, DATA_W=8, WINDOW_W=4).
module tb_sink_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int WW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    ack;
  logic            sink_req;
  logic [DW-1:0]   sink_data;
  logic            sink_busy;
  logic [N*WW-1:0] grant_count;

  always #5 clk = ~clk;

  sink_arbiter #(.N_PORTS(N), .DATA_W(DW), .WINDOW_W(WW)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req         (req),
    .data_in     (data_in),
    .ack         (ack),
    .sink_req    (sink_req),
    .sink_data   (sink_data),
    .sink_busy   (sink_busy),
    .grant_count (grant_count)
  );

  int total = 0;
  int bad   = 0;
  int pushed = 0;
  int delivered = 0;
  logic [DW-1:0] flit_ctr = 8'h60;

  // Requester side: one flit queue per port; front flit is what the port presents.
  logic [DW-1:0] port_q [N][$];
  // Expected sink stream, pushed by the reference model, popped on every sink_req.
  logic [DW-1:0] exp_q[$];

  // Reference model state.
  int            m_ptr;
  logic [N-1:0]  m_ack;
  logic          m_sreq;
  logic [DW-1:0] m_data;

  logic [DW-1:0] s2_data_exp [5];
  logic [N-1:0]  s2_ack_exp  [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += port_q[i].size();
    return s;
  endfunction

  task automatic push_flit(input int p, input logic [DW-1:0] v);
    port_q[p].push_back(v);
    pushed++;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_ack  = '0;
    m_sreq = 1'b0;
    m_data = '0;
  endtask

  task automatic drive_ports();
    for (int i = 0; i < N; i++) begin
      req[i] = (port_q[i].size() > 0);
      data_in[i*DW +: DW] = (port_q[i].size() > 0) ? port_q[i][0] : '0;
    end
  endtask

  // One clock: present flits, predict from the arbitration rules, check after the edge.
  task automatic step();
    logic [N-1:0] elig;
    int w;
    drive_ports();
    elig = req & ~m_ack;
    w = -1;
    if (en && !sink_busy && elig != '0) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    if (w >= 0) begin
      m_ack    = '0;
      m_ack[w] = 1'b1;
      m_sreq   = 1'b1;
      m_data   = port_q[w][0];
      m_ptr    = (w + 1) % N;
      exp_q.push_back(m_data);
    end else begin
      m_ack  = '0;
      m_sreq = 1'b0;
    end
    @(posedge clk);
    #1;
    check("ack", ack, m_ack);
    check("sink_req", sink_req, m_sreq);
    check("sink_data", sink_data, m_data);
    if (sink_req) begin
      check("flit_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("flit_order", sink_data, exp_q.pop_front());
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i] && port_q[i].size() > 0) begin
        void'(port_q[i].pop_front());
        delivered++;
      end
    end
  endtask

  task automatic drain();
    en = 1'b1;
    sink_busy = 1'b0;
    for (int k = 0; k < 80 && pending() > 0; k++) step();
    check("drained", pending(), 0);
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b1;
    sink_busy = 1'b1;
    req = '0;
    data_in = '0;
    model_reset();
    s2_data_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    s2_ack_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_sink_req", sink_req, 0);
    check("rst_sink_data", sink_data, 0);
    check("rst_grant_count", grant_count, 0);
    reset = 1'b0;

    // Sink busy after reset: all ports requesting, nothing issued
    for (int i = 0; i < N; i++) begin
      push_flit(i, 8'h10 + 8'(i));
      push_flit(i, 8'h10 + 8'(i));
    end
    for (int k = 0; k < 5; k++) begin
      step();
      check("busy_no_ack", ack, 0);
      check("busy_no_req", sink_req, 0);
    end

    // All four requesting: strict rotation
    sink_busy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rot_data", sink_data, s2_data_exp[k]);
      check("rot_ack", ack, s2_ack_exp[k]);
    end
    drain();

    // Single port: at most one grant every other cycle
    push_flit(2, 8'h20);
    push_flit(2, 8'h21);
    push_flit(2, 8'h22);
    for (int k = 0; k < 6; k++) begin
      step();
      check("single_ack2", ack[2], (k % 2 == 0));
    end

    // Busy toggling with ports 0 and 2 requesting
    push_flit(0, 8'h30);
    push_flit(0, 8'h31);
    push_flit(2, 8'h40);
    push_flit(2, 8'h41);
    for (int k = 0; k < 8; k++) begin
      sink_busy = (k % 2 == 0);
      step();
      check("busy_toggle_req", sink_req, (k % 2 == 1));
    end
    sink_busy = 1'b0;

    // Reset just before port 1 would be granted; outputs clear without a clock edge
    push_flit(1, 8'h50);
    drive_ports();
    #2;
    reset = 1'b1;
    #1;
    check("async_clr_data", sink_data, 0);
    check("async_clr_ack", ack, 0);
    check("async_clr_req", sink_req, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_ack", ack, 0);
    reset = 1'b0;
    step();
    check("post_rst_ack", ack, 4'b0010);
    check("post_rst_data", sink_data, 8'h50);
    step();
    check("post_rst_once", sink_req, 0);

    // Randomized traffic with random busy and en
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (port_q[i].size() < 3 && $urandom_range(0, 2) == 0) begin
          push_flit(i, flit_ctr);
          flit_ctr++;
        end
      end
      sink_busy = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 7) != 0);
      step();
    end
    drain();

    // Stats window: ports 0 and 1 requesting back-to-back
    for (int k = 0; k < 24; k++) begin
      push_flit(0, flit_ctr);
      flit_ctr++;
      push_flit(1, flit_ctr);
      flit_ctr++;
    end
    for (int k = 0; k < 40; k++) step();
`ifdef SINK_ARB_STATS_EN
    check("gc_port0", grant_count[0*WW +: WW], 8);
    check("gc_port1", grant_count[1*WW +: WW], 8);
    check("gc_port2", grant_count[2*WW +: WW], 0);
    check("gc_port3", grant_count[3*WW +: WW], 0);
`else
    check("gc_tied_zero", grant_count, 0);
`endif
    drain();
    step();

    check("no_loss_no_dup", delivered, pushed);
    check("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
